rforest_feature_loader: RTL and testbench
=========================================

// Module: rforest_feature_loader
// PURPOSE
//  Stream-side front end for the RForest classifier. Accepts one FEAT_W-bit feature
//  per valid/ready beat and assembles N_FEAT features into the flat vector that drives
//  the combinational classifier. It waits SETTLE cycles, captures the class, and returns
//  it on a valid/ready result port. This replaces file-driven stimulus with an in-fabric
//  loader for hardware evaluation of approximate RForest variants.
// PARAMETERS
//  N_FEAT   52  features per sample (classifier inputs in0..in51)
//  FEAT_W   10  bits per feature
//  CLASS_W  5   bits of classifier result
//  SETTLE   1   cycles from vector-complete to class capture; legal range >=1
//  CNT_W    16  width of completed-sample counter
// PORTS
//  clk         in   1               single clock, rising edge
//  rst_n       in   1               asynchronous, active-low reset
//  s_valid     in   1               feature beat valid
//  s_ready     out  1               loader accepts a beat
//  s_data      in   FEAT_W          feature value, sent in order in0 first
//  s_last      in   1               marks the final feature (index N_FEAT-1)
//  feat_bus    out  N_FEAT*FEAT_W   to classifier; feature i at [i*FEAT_W +: FEAT_W]
//  class_in    in   CLASS_W         combinational result from classifier
//  m_valid     out  1               result valid
//  m_ready     in   1               result consumer ready
//  m_class     out  CLASS_W         captured class
//  err_len     out  1               one-cycle pulse on a sample-length violation
//  sample_cnt  out  CNT_W           completed results handed off; wraps to 0
// BEHAVIOUR
//  Reset:
//  - state=LOAD, idx=0; feat_bus, m_valid, m_class, err_len, sample_cnt all 0.
//  FSM LOAD -> SETTLE -> OUT -> LOAD:
//  - s_ready = (state==LOAD), combinational. A beat is accepted when s_valid&s_ready.
//  - LOAD: accepted beat writes feat_bus slot idx, then idx++.
//  - Beat at idx==N_FEAT-1: go to SETTLE, idx<=0.
//  - Beat with s_last=1 at idx<N_FEAT-1: that beat is dropped, err_len pulses, idx<=0,
//    state stays LOAD. Earlier slots keep stale values; they are overwritten by the
//    next sample.
//  - Beat at idx==N_FEAT-1 with s_last=0: sample is still completed and err_len pulses.
//  - SETTLE: a counter counts SETTLE edges. On the SETTLE-th edge after the final
//    accept: m_class<=class_in, m_valid<=1, state<=OUT.
//  - OUT: m_valid and m_class are held until m_valid&m_ready. On that edge: m_valid<=0,
//    sample_cnt++ (mod 2^CNT_W), state<=LOAD. s_ready rises the following cycle.
//  Stability and timing:
//  - feat_bus is stable from the final accept through the OUT handshake.
//  - Latency: m_valid rises SETTLE cycles after the final accept edge.
//  - Minimum period per sample: N_FEAT+SETTLE+1 cycles.
//  - s_valid outside LOAD is ignored; there is no internal buffering.
//  - err_len is registered and high for exactly one cycle per violation.
//  Reset mid-operation:
//  - rst_n low in any state discards the partial sample or pending result immediately
//    and returns everything to reset values.
// STRUCTURE
//  - Shared package rforest_pkg: N_FEAT, FEAT_W, CLASS_W defaults; state enum
//    {LOAD, SETTLE, OUT}; idx width localparam $clog2(N_FEAT).
//  - One sub-module: rforest_feat_regfile, an indexed-write register array with flat
//    output (inputs we, idx, wdata; output feat_bus).
//  - FSM, counters and handshake logic live in the top.
// TESTING
//  1 Reset: hold rst_n=0, then release. Expect s_ready=1, m_valid=0, sample_cnt=0,
//    feat_bus=0.
//  2 Single sample: 52 beats with value = index (0x000..0x033), s_last on beat 51;
//    classifier stub drives class_in=5'd7.
//    Expect feat_bus[9:0]=0x000 and feat_bus[519:510]=0x033.
//    Expect m_valid rises 1 cycle after the last accept and m_class=7.
//    After m_ready: sample_cnt=1.
//  3 Backpressure: m_ready=0 for 20 cycles while s_valid=1.
//    Expect m_valid and m_class stable, s_ready=0, feat_bus unchanged.
//    Release m_ready: one handshake only.
//  4 Early last: s_last=1 on beat 10.
//    Expect err_len pulse and no m_valid; the next full 52-beat sample is classified
//    normally and sample_cnt increments by exactly 1.
//  5 Missing last: 52 beats with s_last=0 throughout.
//    Expect err_len pulse on beat 51 and the result still delivered.
//  6 Reset mid-load at beat 30, then CNT_W=2 run of 5 samples.
//    Expect reset values, then a clean sample; sample_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/rforest_pkg.sv
// Shared constants and types for the RForest stream loader.
package rforest_pkg;

    localparam int RF_N_FEAT  = 52;
    localparam int RF_FEAT_W  = 10;
    localparam int RF_CLASS_W = 5;
    localparam int RF_IDX_W   = $clog2(RF_N_FEAT);

    // Loader sequencing: collect features, let the classifier settle, hand off result.
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

endpackage

// File: rtl/rforest_feat_regfile.sv
// Indexed-write feature register array exposed as one flat vector for the classifier.
module rforest_feat_regfile
    import rforest_pkg::*;
#(
    parameter int N_FEAT = RF_N_FEAT,
    parameter int FEAT_W = RF_FEAT_W,
    parameter int IDX_W  = RF_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [IDX_W-1:0]         idx,
    input  logic [FEAT_W-1:0]        wdata,
    output logic [N_FEAT*FEAT_W-1:0] feat_bus
);

    genvar gi;
    generate
        for (gi = 0; gi < N_FEAT; gi++) begin : g_slot
            logic [FEAT_W-1:0] slot_q;

            // Each slot only loads when its own index is addressed; otherwise it holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (we && (idx == IDX_W'(gi))) begin
                    slot_q <= wdata;
                end
            end

            assign feat_bus[gi*FEAT_W +: FEAT_W] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/rforest_feature_loader.sv
// Stream front end: assembles features, waits for the classifier to settle,
// and returns the captured class over a valid/ready port.
module rforest_feature_loader
    import rforest_pkg::*;
#(
    parameter int N_FEAT  = RF_N_FEAT,
    parameter int FEAT_W  = RF_FEAT_W,
    parameter int CLASS_W = RF_CLASS_W,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]       class_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLASS_W-1:0]       m_class,
    output logic                     err_len,
    output logic [CNT_W-1:0]         sample_cnt
);

    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic               m_valid_q, m_valid_d;
    logic [CLASS_W-1:0] m_class_q, m_class_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               feat_we;
    logic               accept;
    logic               last_slot;

    assign s_ready    = (state_q == ST_LOAD);
    assign accept     = s_valid && s_ready;
    assign last_slot  = (idx_q == IW'(N_FEAT - 1));
    assign m_valid    = m_valid_q;
    assign m_class    = m_class_q;
    assign err_len    = err_q;
    assign sample_cnt = cnt_q;

    rforest_feat_regfile #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W),
        .IDX_W  (IW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (feat_we),
        .idx      (idx_q),
        .wdata    (s_data),
        .feat_bus (feat_bus)
    );

    // State, index, settle counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            settle_q  <= '0;
            m_valid_q <= 1'b0;
            m_class_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; err_d defaults low so a length error is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        feat_we   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (last_slot) begin
                        // Final slot completes the sample even without s_last.
                        feat_we  = 1'b1;
                        idx_d    = '0;
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                        err_d    = !s_last;
                    end else if (s_last) begin
                        // Short sample: drop the beat and restart at slot 0.
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        feat_we = 1'b1;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    m_class_d = class_in;
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_rforest_feature_loader.sv
// Scenario bench for the RForest feature loader with an expected-class scoreboard.
module tb_rforest_feature_loader;
    import rforest_pkg::*;

    localparam int NF = 52;
    localparam int FW = 10;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic [FW-1:0] s_data = '0;
    logic [CW-1:0] class_in = '0;

    logic             s_ready, m_valid, err_len;
    logic [NF*FW-1:0] feat_bus;
    logic [CW-1:0]    m_class;
    logic [15:0]      sample_cnt;

    logic             b_s_ready, b_m_valid, b_err_len;
    logic [NF*FW-1:0] b_feat_bus;
    logic [CW-1:0]    b_m_class;
    logic [1:0]       b_sample_cnt;

    rforest_feature_loader #(.SETTLE(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .feat_bus(feat_bus), .class_in(class_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .err_len(err_len), .sample_cnt(sample_cnt)
    );

    rforest_feature_loader #(.SETTLE(1), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_last(s_last), .feat_bus(b_feat_bus), .class_in(class_in),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_class(b_m_class),
        .err_len(b_err_len), .sample_cnt(b_sample_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [CW-1:0]    exp_q[$];
    logic [NF*FW-1:0] exp_bus = '0;
    int model_idx = 0;
    logic [15:0] exp_cnt = '0;
    logic [1:0]  exp_cnt2 = '0;

    // Drive n beats; the model tracks slot writes, length errors and completed samples.
    task automatic send_beats(input int n, input int last_at, input bit rand_data);
        for (int i = 0; i < n; i++) begin
            logic [FW-1:0] d;
            logic exp_err;
            int g;
            d = rand_data ? FW'($urandom) : FW'(i);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == last_at);
            g = 0;
            while (!s_ready && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            total++;
            if (s_ready !== 1'b1) begin
                bad++;
                $display("FAIL beat_ready beat=%0d got=%b want=1", i, s_ready);
            end
            exp_err = 1'b0;
            if (model_idx == NF - 1) begin
                exp_bus[model_idx*FW +: FW] = d;
                exp_q.push_back(class_in);
                model_idx = 0;
                exp_err = (i != last_at);
            end else if (i == last_at) begin
                model_idx = 0;
                exp_err = 1'b1;
            end else begin
                exp_bus[model_idx*FW +: FW] = d;
                model_idx++;
            end
            @(posedge clk); #1;
            total++;
            if (err_len !== exp_err) begin
                bad++;
                $display("FAIL err_len beat=%0d got=%b want=%b", i, err_len, exp_err);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Scoreboard consumer: wait for a result, compare against the queue head, handshake once.
    task automatic drain_result(input string tag);
        int g;
        logic [CW-1:0] e;
        g = 0;
        while (!m_valid && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        total++;
        if (m_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_m_valid_timeout got=%b want=1", tag, m_valid);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_scoreboard_empty got=%0d want=expected entry", tag, m_class);
        end else begin
            e = exp_q.pop_front();
            if (m_class !== e || b_m_class !== e) begin
                bad++;
                $display("FAIL %s_m_class got=%0d/%0d want=%0d", tag, m_class, b_m_class, e);
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        exp_cnt  = exp_cnt + 16'd1;
        exp_cnt2 = exp_cnt2 + 2'd1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_after_hs got=m_valid %b s_ready %b want=0 1", tag, m_valid, s_ready);
        end
        total++;
        if (sample_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL %s_sample_cnt got=%0d want=%0d", tag, sample_cnt, exp_cnt);
        end
        total++;
        if (b_sample_cnt !== exp_cnt2) begin
            bad++;
            $display("FAIL %s_sample_cnt_w2 got=%0d want=%0d", tag, b_sample_cnt, exp_cnt2);
        end
        $display("result %s class=%0d cnt=%0d cnt2=%0d", tag, m_class, sample_cnt, b_sample_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || sample_cnt !== 16'd0 || err_len !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got=rdy %b vld %b cnt %0d err %b want=1 0 0 0",
                     s_ready, m_valid, sample_cnt, err_len);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (feat_bus !== '0 || m_class !== '0 || b_sample_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_release got=bus_nonzero %b class %0d cnt2 %0d want=0 0 0",
                     |feat_bus, m_class, b_sample_cnt);
        end
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_hs got=rdy %b vld %b want=1 0", s_ready, m_valid);
        end
        $display("reset done");
    endtask

    task automatic test_single();
        logic [FW-1:0] lo, hi;
        class_in = 5'd7;
        send_beats(NF, NF - 1, 1'b0);
        lo = feat_bus[9:0];
        hi = feat_bus[519:510];
        total++;
        if (lo !== 10'h000 || hi !== 10'h033) begin
            bad++;
            $display("FAIL single_slots got=%h %h want=000 033", lo, hi);
        end
        total++;
        if (feat_bus !== exp_bus) begin
            bad++;
            $display("FAIL single_feat_bus got=%h want=%h", feat_bus, exp_bus);
        end
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early_valid got=%b want=0", m_valid);
        end
        @(posedge clk); #1;
        total++;
        if (m_valid !== 1'b1 || m_class !== 5'd7) begin
            bad++;
            $display("FAIL single_latency got=vld %b class %0d want=1 7", m_valid, m_class);
        end
        drain_result("single");
    endtask

    task automatic test_backpressure();
        int g;
        logic [CW-1:0] held;
        class_in = CW'($urandom);
        send_beats(NF, NF - 1, 1'b1);
        g = 0;
        while (!m_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        held = class_in;
        class_in = ~class_in;
        s_valid = 1'b1;
        s_data = 10'h3FF;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            total++;
            if (m_valid !== 1'b1 || m_class !== held || s_ready !== 1'b0 || feat_bus !== exp_bus) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got=vld %b class %0d rdy %b want=1 %0d 0",
                         c, m_valid, m_class, s_ready, held);
            end
        end
        s_valid = 1'b0;
        drain_result("backpressure");
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        total++;
        if (sample_cnt !== exp_cnt || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_single_hs got=cnt %0d vld %b want=%0d 0", sample_cnt, m_valid, exp_cnt);
        end
    endtask

    task automatic test_early_last();
        class_in = 5'd3;
        send_beats(11, 10, 1'b1);
        @(posedge clk); #1;
        total++;
        if (err_len !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL early_after got=err %b vld %b rdy %b want=0 0 1", err_len, m_valid, s_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_no_result got=%b want=0", m_valid);
        end
        class_in = 5'd9;
        send_beats(NF, NF - 1, 1'b1);
        total++;
        if (feat_bus !== exp_bus) begin
            bad++;
            $display("FAIL early_next_bus got=%h want=%h", feat_bus, exp_bus);
        end
        drain_result("early_next");
    endtask

    task automatic test_missing_last();
        class_in = 5'd21;
        send_beats(NF, -1, 1'b1);
        total++;
        if (feat_bus !== exp_bus) begin
            bad++;
            $display("FAIL missing_bus got=%h want=%h", feat_bus, exp_bus);
        end
        drain_result("missing_last");
    endtask

    task automatic test_reset_mid();
        class_in = 5'd11;
        send_beats(30, -1, 1'b1);
        rst_n = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || feat_bus !== '0 || sample_cnt !== 16'd0
            || b_sample_cnt !== 2'd0 || err_len !== 1'b0) begin
            bad++;
            $display("FAIL midrst_values got=rdy %b vld %b bus_nz %b cnt %0d cnt2 %0d want=1 0 0 0 0",
                     s_ready, m_valid, |feat_bus, sample_cnt, b_sample_cnt);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_idx = 0;
        exp_bus = '0;
        exp_cnt = '0;
        exp_cnt2 = '0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            class_in = CW'($urandom);
            send_beats(NF, NF - 1, 1'b1);
            total++;
            if (feat_bus !== exp_bus) begin
                bad++;
                $display("FAIL wrap_bus sample=%0d got=%h want=%h", k, feat_bus, exp_bus);
            end
            drain_result($sformatf("wrap%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
